// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - receive-side LFSR stream checker: self-sync, flywheel prediction, error count
module lfsr_checker #(
    parameter int                  BITWIDTH     = 10,
    parameter logic [BITWIDTH-1:0] TAP          = 10'b0100010001,
    parameter int                  LOCK_COUNT   = 4,
    parameter int                  UNLOCK_COUNT = 4,
    parameter int                  CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clr,
    input  logic                in_valid,
    input  logic [BITWIDTH-1:0] in_data,
    output logic                locked,
    output logic                err,
    output logic [CNT_W-1:0]    err_cnt,
    output logic                zero_seen
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int UW = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t                state_q, state_d;
    logic [BITWIDTH-1:0]   expected_q, expected_d;
    logic [MW-1:0]         match_run_q, match_run_d;
    logic [UW-1:0]         bad_run_q, bad_run_d;
    logic                  err_d;
    logic [CNT_W-1:0]      err_cnt_d;
    logic                  zero_seen_d;
    logic [MW-1:0]         match_inc;
    logic [UW-1:0]         bad_inc;
    logic                  is_zero;
    logic                  is_match;

    function automatic logic [BITWIDTH-1:0] nxt(input logic [BITWIDTH-1:0] s);
        return {^(s & TAP), s[BITWIDTH-1:1]};
    endfunction

    assign match_inc = match_run_q + MW'(1);
    assign bad_inc   = bad_run_q + UW'(1);
    assign is_zero   = (in_data == '0);
    assign is_match  = (in_data == expected_q);

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_run_d = match_run_q;
        bad_run_d   = bad_run_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt;
        zero_seen_d = zero_seen;
        if (clr) begin
            state_d     = SEARCH;
            match_run_d = '0;
            bad_run_d   = '0;
            err_cnt_d   = '0;
            zero_seen_d = 1'b0;
        end else if (in_valid) begin
            if (is_zero) begin
                zero_seen_d = 1'b1;
            end
            unique case (state_q)
                SEARCH: begin
                    if (!is_zero) begin
                        expected_d  = nxt(in_data);
                        match_run_d = '0;
                        state_d     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (is_zero) begin
                        match_run_d = '0;
                        state_d     = SEARCH;
                    end else if (is_match) begin
                        expected_d  = nxt(in_data);
                        match_run_d = match_inc;
                        if (match_inc == MW'(LOCK_COUNT)) begin
                            state_d   = LOCKED;
                            bad_run_d = '0;
                        end
                    end else begin
                        expected_d  = nxt(in_data);
                        match_run_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: prediction advances from its own state, never from data.
                    expected_d = nxt(expected_q);
                    if (is_match) begin
                        bad_run_d = '0;
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = (&err_cnt) ? err_cnt : err_cnt + CNT_W'(1);
                        bad_run_d = bad_inc;
                        if (bad_inc == UW'(UNLOCK_COUNT)) begin
                            state_d     = SEARCH;
                            match_run_d = '0;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= SEARCH;
            expected_q  <= '0;
            match_run_q <= '0;
            bad_run_q   <= '0;
            err         <= 1'b0;
            err_cnt     <= '0;
            zero_seen   <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_run_q <= match_run_d;
            bad_run_q   <= bad_run_d;
            err         <= err_d;
            err_cnt     <= err_cnt_d;
            zero_seen   <= zero_seen_d;
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed self-checking bench for lfsr_checker
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clr;
    logic        in_valid;
    logic [9:0]  in_data;
    logic        locked, err, zero_seen;
    logic [15:0] err_cnt;
    logic        locked3, err3, zero_seen3;
    logic [2:0]  err_cnt3;

    int checks = 0;
    int errors = 0;
    logic [9:0] cur;

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .locked(locked), .err(err), .err_cnt(err_cnt), .zero_seen(zero_seen)
    );

    lfsr_checker #(.CNT_W(3)) dut3 (
        .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .locked(locked3), .err(err3), .err_cnt(err_cnt3), .zero_seen(zero_seen3)
    );

    function automatic logic [9:0] nxt(input logic [9:0] s);
        return {s[8] ^ s[4] ^ s[0], s[9:1]};
    endfunction

    task automatic send(input logic [9:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic lock_up();
        for (int i = 0; i < 5; i++) begin
            send(cur);
            cur = nxt(cur);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        #3;
        checks++;
        if ({locked, err, err_cnt, zero_seen} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 0", {locked, err, err_cnt, zero_seen});
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lock();
        cur = 10'h001;
        checks++;
        if (nxt(cur) !== 10'h200) begin
            errors++;
            $display("FAIL chain_start got %h expected 200", nxt(cur));
        end
        for (int i = 0; i < 5; i++) begin
            send(cur);
            cur = nxt(cur);
            checks++;
            if ({locked, err} !== {(i == 4), 1'b0}) begin
                errors++;
                $display("FAIL lock_sample%0d got locked=%b err=%b expected locked=%b err=0",
                         i, locked, err, (i == 4));
            end
        end
    endtask

    task automatic test_single_err();
        send(cur ^ 10'h001);
        cur = nxt(cur);
        checks++;
        if ({locked, err, err_cnt} !== {2'b11, 16'd1}) begin
            errors++;
            $display("FAIL single_err got locked=%b err=%b cnt=%0d expected 1 1 1", locked, err, err_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            send(cur);
            cur = nxt(cur);
            checks++;
            if ({locked, err, err_cnt} !== {2'b10, 16'd1}) begin
                errors++;
                $display("FAIL single_err_after%0d got locked=%b err=%b cnt=%0d expected 1 0 1",
                         i, locked, err, err_cnt);
            end
        end
    endtask

    task automatic test_unlock();
        clr_pulse();
        lock_up();
        checks++;
        if ({locked, err_cnt} !== {1'b1, 16'd0}) begin
            errors++;
            $display("FAIL unlock_prelock got locked=%b cnt=%0d expected 1 0", locked, err_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            send(cur ^ 10'h001);
            cur = nxt(cur);
            checks++;
            if ({locked, err, err_cnt} !== {(i < 3), 1'b1, 16'(i + 1)}) begin
                errors++;
                $display("FAIL unlock_bad%0d got locked=%b err=%b cnt=%0d expected %b 1 %0d",
                         i, locked, err, err_cnt, (i < 3), i + 1);
            end
        end
        for (int i = 0; i < 5; i++) begin
            send(cur);
            cur = nxt(cur);
            checks++;
            if ({locked, err, err_cnt} !== {(i == 4), 1'b0, 16'd4}) begin
                errors++;
                $display("FAIL relock%0d got locked=%b err=%b cnt=%0d expected %b 0 4",
                         i, locked, err, err_cnt, (i == 4));
            end
        end
    endtask

    task automatic test_zero();
        clr_pulse();
        checks++;
        if ({zero_seen, err_cnt, locked} !== 18'd0) begin
            errors++;
            $display("FAIL clr_state got zs=%b cnt=%0d locked=%b expected 0 0 0", zero_seen, err_cnt, locked);
        end
        send(10'h000);
        checks++;
        if ({zero_seen, locked, err} !== 3'b100) begin
            errors++;
            $display("FAIL zero_search got zs/locked/err=%b expected 100", {zero_seen, locked, err});
        end
        send(cur); cur = nxt(cur);
        send(cur); cur = nxt(cur);
        send(10'h000);
        checks++;
        if ({zero_seen, locked, err} !== 3'b100) begin
            errors++;
            $display("FAIL zero_verify got zs/locked/err=%b expected 100", {zero_seen, locked, err});
        end
        // A zero in VERIFY must fall back to SEARCH, so re-lock takes the full five samples.
        for (int i = 0; i < 5; i++) begin
            send(cur);
            cur = nxt(cur);
            checks++;
            if ({locked, err, zero_seen} !== {(i == 4), 2'b01}) begin
                errors++;
                $display("FAIL zero_relock%0d got locked=%b err=%b zs=%b expected %b 0 1",
                         i, locked, err, zero_seen, (i == 4));
            end
        end
        send(10'h000);
        cur = nxt(cur);
        checks++;
        if ({locked, err, err_cnt} !== {2'b11, 16'd1}) begin
            errors++;
            $display("FAIL zero_locked got locked=%b err=%b cnt=%0d expected 1 1 1", locked, err, err_cnt);
        end
        send(cur);
        cur = nxt(cur);
        checks++;
        if ({locked, err, err_cnt} !== {2'b10, 16'd1}) begin
            errors++;
            $display("FAIL zero_locked_after got locked=%b err=%b cnt=%0d expected 1 0 1", locked, err, err_cnt);
        end
    endtask

    task automatic test_saturate();
        clr_pulse();
        lock_up();
        for (int i = 0; i < 10; i++) begin
            send(cur ^ (10'h001 << (i % 10)));
            cur = nxt(cur);
            checks++;
            if ({err_cnt3, err_cnt} !== {((i + 1) > 7 ? 3'd7 : 3'(i + 1)), 16'(i + 1)}) begin
                errors++;
                $display("FAIL sat_err%0d got cnt3=%0d cnt=%0d expected %0d %0d",
                         i, err_cnt3, err_cnt, ((i + 1) > 7 ? 7 : i + 1), i + 1);
            end
            for (int j = 0; j < 3; j++) begin
                send(cur);
                cur = nxt(cur);
            end
        end
        checks++;
        if ({locked3, err3, err_cnt3} !== 5'b10111) begin
            errors++;
            $display("FAIL sat_hold got locked=%b err=%b cnt3=%0d expected 1 0 7", locked3, err3, err_cnt3);
        end
        clr_pulse();
        checks++;
        if ({locked3, err_cnt3, locked, err_cnt} !== 21'd0) begin
            errors++;
            $display("FAIL sat_clr got locked3=%b cnt3=%0d locked=%b cnt=%0d expected all 0",
                     locked3, err_cnt3, locked, err_cnt);
        end
    endtask

    task automatic test_gaps();
        clr_pulse();
        cur = 10'h001;
        for (int i = 0; i < 5; i++) begin
            send(cur);
            cur = nxt(cur);
            checks++;
            if ({locked, err} !== {(i == 4), 1'b0}) begin
                errors++;
                $display("FAIL gap_sample%0d got locked=%b err=%b expected %b 0", i, locked, err, (i == 4));
            end
            for (int g = 0; g < (i % 4); g++) begin
                @(posedge clk);
                #1;
                checks++;
                if ({locked, err} !== {(i == 4), 1'b0}) begin
                    errors++;
                    $display("FAIL gap_idle%0d_%0d got locked=%b err=%b expected %b 0",
                             i, g, locked, err, (i == 4));
                end
            end
        end
        send(10'h000);
        checks++;
        if ({locked, err, err_cnt, zero_seen} !== {2'b11, 16'd1, 1'b1}) begin
            errors++;
            $display("FAIL pre_rst got locked=%b err=%b cnt=%0d zs=%b expected 1 1 1 1",
                     locked, err, err_cnt, zero_seen);
        end
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if ({locked, err, err_cnt, zero_seen} !== 19'd0) begin
            errors++;
            $display("FAIL async_rst got %b expected 0", {locked, err, err_cnt, zero_seen});
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_err();
        test_unlock();
        test_zero();
        test_saturate();
        test_gaps();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
